// File: rtl/veda_mem_if.sv
// Operation/result bus of the scratch memory controller: request handshake,
// clear request and result channel grouped for master (command side) and slave (memory side).
interface veda_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic              mode;
    logic              we;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic [DATA_W-1:0] data_out;
    logic              collide;
    logic              busy;

    modport master (
        output clr, in_valid, mode, we, addr_a, addr_b, data_in,
        input  in_ready, out_valid, data_out, collide, busy
    );

    modport slave (
        input  clr, in_valid, mode, we, addr_a, addr_b, data_in,
        output in_ready, out_valid, data_out, collide, busy
    );
endinterface

// File: rtl/veda_mem_ctrl.sv
// Scratch memory with sequenced clear engine, RD_LAT-stage result pipeline and
// a parameterised policy for same-address write/read collisions.
module veda_mem_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int RD_LAT       = 1,
    parameter int COLLIDE_MODE = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    veda_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              in_ready_s;
    logic              busy_s;
    logic              accept_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              res_valid_s;
    logic              res_col_s;
    logic [DATA_W-1:0] res_data_s;
    logic              op_wr_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    logic [RD_LAT-1:0] pv_r;
    logic [RD_LAT-1:0] pc_r;
    logic [DATA_W-1:0] pd_r [RD_LAT];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: clear runs to the last word, clr request restarts it
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == {ADDR_W{1'b1}}) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (bus.clr) begin
                    state_nx_s = ST_CLEAR;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_CLEAR;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            ST_CLEAR: busy_s     = 1'b1;
            ST_RUN:   in_ready_s = !bus.clr;
            default:  busy_s     = 1'b1;
        endcase
    end

    // Clear address counter, held at zero outside CLEAR so every clear starts at word 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            clr_cnt_r <= clr_cnt_r + 1'b1;
        end else begin
            clr_cnt_r <= {ADDR_W{1'b0}};
        end
    end

    assign accept_s  = bus.in_valid && in_ready_s;
    assign rd_word_s = mem_r[bus.addr_b];

    // Operation decode; reads always see the pre-write word of this cycle
    always_comb begin
        res_valid_s = 1'b0;
        res_col_s   = 1'b0;
        res_data_s  = rd_word_s;
        op_wr_s     = 1'b0;
        if (accept_s) begin
            case ({bus.mode, bus.we})
                2'b01: begin
                    op_wr_s     = 1'b1;
                    res_valid_s = 1'b1;
                    res_data_s  = bus.data_in;
                end
                2'b10: begin
                    res_valid_s = 1'b1;
                end
                2'b11: begin
                    if (bus.addr_a == bus.addr_b) begin
                        res_col_s = 1'b1;
                        if (COLLIDE_MODE == 32'sd0) begin
                            op_wr_s     = 1'b1;
                            res_valid_s = 1'b1;
                        end else if (COLLIDE_MODE == 32'sd1) begin
                            op_wr_s     = 1'b1;
                            res_valid_s = 1'b1;
                            res_data_s  = bus.data_in;
                        end else begin
                            op_wr_s     = 1'b0;
                            res_valid_s = 1'b0;
                        end
                    end else begin
                        op_wr_s     = 1'b1;
                        res_valid_s = 1'b1;
                    end
                end
                default: begin
                    res_valid_s = 1'b0;
                end
            endcase
        end else begin
            res_valid_s = 1'b0;
        end
    end

    // Single write port shared by the clear engine and accepted operations
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = bus.addr_a;
        wr_data_s = bus.data_in;
        if (state_r == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_cnt_r;
            wr_data_s = {DATA_W{1'b0}};
        end else begin
            wr_en_s = op_wr_s;
        end
    end

    // Memory array; reset deliberately leaves contents alone
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Result pipeline; data registers only move with a valid result so data_out holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_r <= {RD_LAT{1'b0}};
            pc_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                pd_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            pv_r[0] <= res_valid_s;
            pc_r[0] <= res_col_s;
            if (res_valid_s) begin
                pd_r[0] <= res_data_s;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pv_r[i] <= pv_r[i-1];
                pc_r[i] <= pc_r[i-1];
                if (pv_r[i-1]) begin
                    pd_r[i] <= pd_r[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.busy      = busy_s;
    assign bus.out_valid = pv_r[RD_LAT-1];
    assign bus.collide   = pc_r[RD_LAT-1];
    assign bus.data_out  = pd_r[RD_LAT-1];
endmodule

// File: tb/tb_veda_mem_ctrl.sv
// Bench for veda_mem_ctrl: three configurations share one stimulus stream and are
// each compared every cycle against an independent reference model.
module tb_veda_mem_ctrl;
    localparam int NDUT = 3;
    localparam int LAT [NDUT] = '{1, 2, 2};
    localparam int CM  [NDUT] = '{0, 1, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr_a = 5'd0;
    logic [4:0]  addr_b = 5'd0;
    logic [31:0] data_in = 32'd0;

    logic [NDUT-1:0] ov_s, oc_s, ir_s, bz_s;
    logic [31:0]     od_s [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        veda_mem_if #(.DATA_W(32), .ADDR_W(5)) bus ();
        assign bus.clr      = clr;
        assign bus.in_valid = in_valid;
        assign bus.mode     = mode;
        assign bus.we       = we;
        assign bus.addr_a   = addr_a;
        assign bus.addr_b   = addr_b;
        assign bus.data_in  = data_in;
        assign ov_s[g]      = bus.out_valid;
        assign oc_s[g]      = bus.collide;
        assign ir_s[g]      = bus.in_ready;
        assign bz_s[g]      = bus.busy;
        assign od_s[g]      = bus.data_out;
        veda_mem_ctrl #(.DATA_W(32), .ADDR_W(5), .RD_LAT(LAT[g]), .COLLIDE_MODE(CM[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Reference model: memory image, run/clear flag and a schedule of future results
    bit          run_m  [NDUT];
    int          cnt_m  [NDUT];
    logic [31:0] mem_m  [NDUT][32];
    bit          fv_m   [NDUT][4];
    bit          fc_m   [NDUT][4];
    logic [31:0] fd_m   [NDUT][4];
    bit          exp_ov [NDUT];
    bit          exp_oc [NDUT];
    logic [31:0] exp_do [NDUT];
    int          edge_n = 0;

    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) begin
                run_m[k] = 1'b0;
                cnt_m[k] = 0;
                for (int s = 0; s < 4; s++) begin
                    fv_m[k][s] = 1'b0;
                    fc_m[k][s] = 1'b0;
                end
                exp_ov[k] = 1'b0;
                exp_oc[k] = 1'b0;
                exp_do[k] = 32'd0;
            end else begin
                if (in_valid && run_m[k] && !clr) begin
                    int slot = (edge_n + LAT[k] - 1) % 4;
                    bit rv = 1'b0, rc = 1'b0, wr = 1'b0;
                    logic [31:0] rd = 32'd0;
                    if (!mode && we) begin
                        wr = 1'b1; rv = 1'b1; rd = data_in;
                    end else if (mode && !we) begin
                        rv = 1'b1; rd = mem_m[k][addr_b];
                    end else if (mode && we && addr_a != addr_b) begin
                        wr = 1'b1; rv = 1'b1; rd = mem_m[k][addr_b];
                    end else if (mode && we) begin
                        rc = 1'b1;
                        if (CM[k] == 0) begin
                            wr = 1'b1; rv = 1'b1; rd = mem_m[k][addr_a];
                        end else if (CM[k] == 1) begin
                            wr = 1'b1; rv = 1'b1; rd = data_in;
                        end
                    end
                    fv_m[k][slot] = rv;
                    fc_m[k][slot] = rc;
                    fd_m[k][slot] = rd;
                    if (wr) mem_m[k][addr_a] = data_in;
                end
                if (!run_m[k]) begin
                    mem_m[k][cnt_m[k]] = 32'd0;
                    if (cnt_m[k] == 31) run_m[k] = 1'b1;
                    cnt_m[k] = cnt_m[k] + 1;
                end else if (clr) begin
                    run_m[k] = 1'b0;
                    cnt_m[k] = 0;
                end
                exp_ov[k] = fv_m[k][edge_n % 4];
                exp_oc[k] = fc_m[k][edge_n % 4];
                if (fv_m[k][edge_n % 4]) exp_do[k] = fd_m[k][edge_n % 4];
                fv_m[k][edge_n % 4] = 1'b0;
                fc_m[k][edge_n % 4] = 1'b0;
            end
        end
        edge_n = edge_n + 1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, k, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("out_valid", k, {31'd0, ov_s[k]}, {31'd0, exp_ov[k]});
            chk("collide",   k, {31'd0, oc_s[k]}, {31'd0, exp_oc[k]});
            chk("data_out",  k, od_s[k], exp_do[k]);
            chk("busy",      k, {31'd0, bz_s[k]}, {31'd0, !run_m[k]});
            chk("in_ready",  k, {31'd0, ir_s[k]}, {31'd0, run_m[k] && !clr});
        end
    endtask

    task automatic drive(input logic v, input logic m, input logic w,
                         input logic [4:0] a, input logic [4:0] b, input logic [31:0] d);
        in_valid = v; mode = m; we = w; addr_a = a; addr_b = b; data_in = d;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 32; i++) mem_m[k][i] = 32'd0;

        // Reset, then full clear of 32 cycles
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0);
        repeat (32) tick();
        // Cleared words read zero
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0);  tick();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd17, 32'd0); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd31, 32'd0); tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);  tick(); tick();
        // Scribble then immediate readback
        drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 32'd0);        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);        repeat (3) tick();
        // Same-address collision
        drive(1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 32'h11); tick();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 32'h22); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 32'd0);  tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);  repeat (3) tick();
        // Back-to-back writes and reads of 0..7
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, 5'(i), 5'd0, $urandom); tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd0, 5'(i), 32'd0); tick();
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0); repeat (3) tick();
        // clr with a pending op: not accepted, full clear, earlier writes gone
        drive(1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 32'hCAFE0001); clr = 1'b1; tick();
        clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0); repeat (34) tick();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 32'd0); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 32'd0); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd9, 32'd0); tick();
        // Reset with a result still in flight, then reset again mid-clear
        drive(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 32'h0BADF00D); tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);
        rst_n = 1'b0; tick();
        rst_n = 1'b1; repeat (10) tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; repeat (34) tick();
        // Randomised traffic over a narrow address range to provoke collisions
        repeat (500) begin
            drive(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
            clr = (($urandom % 60) == 0);
            tick();
        end
        clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0); repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
